// File: rtl/udp_rx_depacketizer.sv
// Eth/IPv4/UDP receive depacketizer: captures and validates the 42-byte header,
// hands the fields out on their own channel and realigns the payload to byte 0.
module udp_rx_depacketizer #(
    parameter int DATA_W    = 128,
    parameter int FILTER_EN = 0,
    parameter int CNT_W     = 32
) (
    input  logic                  wClk,
    input  logic                  wRst,
    input  logic [DATA_W-1:0]     bData_in_data_in,
    input  logic [DATA_W/8-1:0]   bData_in_keep_in,
    input  logic                  wData_in_valid_in,
    input  logic                  wData_in_last_in,
    output logic                  wData_in_ready_in,
    input  logic [15:0]           bFilter_port,
    output logic [47:0]           bHdr_mac_dst,
    output logic [47:0]           bHdr_mac_src,
    output logic [31:0]           bHdr_ip_src,
    output logic [31:0]           bHdr_ip_dst,
    output logic [15:0]           bHdr_ip_len,
    output logic [15:0]           bHdr_ip_id,
    output logic [15:0]           bHdr_udp_src,
    output logic [15:0]           bHdr_udp_dst,
    output logic [15:0]           bHdr_udp_len,
    output logic                  wHdr_valid,
    input  logic                  wHdr_ready,
    output logic [DATA_W-1:0]     bData_out_data_out,
    output logic [DATA_W/8-1:0]   bData_out_keep_out,
    output logic                  wData_out_valid_out,
    output logic                  wData_out_last_out,
    input  logic                  wData_out_ready_out,
    output logic [CNT_W-1:0]      bBadCheckSum_cnt,
    output logic [CNT_W-1:0]      bEarlyTerminate_cnt,
    output logic [CNT_W-1:0]      bUnsupportType_cnt,
    output logic [CNT_W-1:0]      bFiltered_cnt
);
    localparam int W  = DATA_W / 8;
    localparam int O  = 42 % W;
    localparam int HB = 42;
    localparam logic [6:0] W7  = 7'(W);
    localparam logic [6:0] O7  = 7'(O);
    localparam logic [6:0] HB7 = 7'(HB);

    typedef enum logic [2:0] {S_HDR, S_HDR_OUT, S_PAYLOAD, S_FLUSH, S_DROP} state_t;

    function automatic logic [W-1:0] f_mask(input logic [6:0] n);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < W; i++)
            if (7'(i) < n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] f_b(input logic [HB*8-1:0] h, input int i);
        return h[8*i +: 8];
    endfunction

    function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    state_t              r_state;
    logic [6:0]          r_cnt;
    logic [6:0]          r_res_cnt;
    logic                r_last;
    logic [HB*8-1:0]     r_hdr;
    logic [DATA_W-1:0]   r_res;
    logic [DATA_W-1:0]   r_out_data;
    logic [W-1:0]        r_out_keep;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_hdr_valid;
    logic [CNT_W-1:0]    r_bad;
    logic [CNT_W-1:0]    r_early;
    logic [CNT_W-1:0]    r_unsup;
    logic [CNT_W-1:0]    r_filt;

    logic [HB*8-1:0]     w_hdr;
    logic [6:0]          w_k;
    logic [6:0]          w_tot;
    logic                w_load;
    logic                w_acc;
    logic                w_fire;
    logic                w_unsup;
    logic                w_bad;
    logic                w_filt;
    logic [19:0]         w_sum;
    logic [16:0]         w_f1;
    logic [15:0]         w_f2;

    // header image as it will look once the current beat is absorbed
    always_comb begin
        w_hdr = r_hdr;
        for (int i = 0; i < HB; i++)
            for (int j = 0; j < W; j++)
                if (bData_in_keep_in[j] && (int'(r_cnt) + j == i))
                    w_hdr[8*i +: 8] = bData_in_data_in[8*j +: 8];
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 10; i++)
            w_sum = w_sum + {4'd0, f_b(w_hdr, 14 + 2*i), f_b(w_hdr, 15 + 2*i)};
    end

    assign w_f1 = {1'b0, w_sum[15:0]} + {13'd0, w_sum[19:16]};
    assign w_f2 = w_f1[15:0] + {15'd0, w_f1[16]};

    assign w_unsup = ({f_b(w_hdr, 12), f_b(w_hdr, 13)} != 16'h0800) ||
                     (f_b(w_hdr, 14) != 8'h45) || (f_b(w_hdr, 23) != 8'd17);
    assign w_bad   = (w_f2 != 16'hFFFF);
    assign w_filt  = (FILTER_EN != 0) &&
                     ({f_b(w_hdr, 36), f_b(w_hdr, 37)} != bFilter_port);

    assign w_k    = 7'($countones(bData_in_keep_in));
    assign w_tot  = r_cnt + w_k;
    assign w_load = !r_out_valid || wData_out_ready_out;

    always_comb begin
        w_acc = 1'b0;
        unique case (r_state)
            S_HDR, S_DROP: w_acc = 1'b1;
            S_PAYLOAD:     w_acc = w_load;
            default:       w_acc = 1'b0;
        endcase
    end

    assign wData_in_ready_in = w_acc && !wRst;
    assign w_fire = wData_in_valid_in && wData_in_ready_in;

    always_ff @(posedge wClk or posedge wRst) begin
        if (wRst) begin
            r_state     <= S_HDR;
            r_cnt       <= '0;
            r_res_cnt   <= '0;
            r_last      <= 1'b0;
            r_hdr       <= '0;
            r_res       <= '0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_hdr_valid <= 1'b0;
            r_bad       <= '0;
            r_early     <= '0;
            r_unsup     <= '0;
            r_filt      <= '0;
        end else begin
            if (r_out_valid && wData_out_ready_out) r_out_valid <= 1'b0;
            unique case (r_state)
                S_HDR: if (w_fire) begin
                    r_hdr <= w_hdr;
                    if (w_tot < HB7) begin
                        r_cnt <= w_tot;
                        if (wData_in_last_in) begin
                            r_early <= f_inc(r_early);
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_cnt     <= '0;
                        r_res     <= bData_in_data_in >> (O*8);
                        r_res_cnt <= w_k - O7;
                        r_last    <= wData_in_last_in;
                        if (w_unsup) begin
                            r_unsup <= f_inc(r_unsup);
                            r_state <= wData_in_last_in ? S_HDR : S_DROP;
                        end else if (w_bad) begin
                            r_bad   <= f_inc(r_bad);
                            r_state <= wData_in_last_in ? S_HDR : S_DROP;
                        end else if (w_filt) begin
                            r_filt  <= f_inc(r_filt);
                            r_state <= wData_in_last_in ? S_HDR : S_DROP;
                        end else begin
                            r_hdr_valid <= 1'b1;
                            r_state     <= S_HDR_OUT;
                        end
                    end
                end
                S_HDR_OUT: if (wHdr_ready) begin
                    r_hdr_valid <= 1'b0;
                    if (!r_last)              r_state <= S_PAYLOAD;
                    else if (r_res_cnt != '0) r_state <= S_FLUSH;
                    else                      r_state <= S_HDR;
                end
                S_PAYLOAD: if (w_fire) begin
                    r_out_data  <= {bData_in_data_in[O*8-1:0], r_res[(W-O)*8-1:0]};
                    r_out_valid <= 1'b1;
                    r_out_keep  <= '1;
                    r_out_last  <= 1'b0;
                    r_res       <= bData_in_data_in >> (O*8);
                    if (wData_in_last_in) begin
                        if (w_k <= O7) begin
                            r_out_keep <= f_mask(W7 - O7 + w_k);
                            r_out_last <= 1'b1;
                            r_state    <= S_HDR;
                        end else begin
                            r_res_cnt <= w_k - O7;
                            r_state   <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: if (w_load) begin
                    r_out_data  <= r_res;
                    r_out_keep  <= f_mask(r_res_cnt);
                    r_out_last  <= 1'b1;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HDR;
                end
                S_DROP: if (w_fire && wData_in_last_in) r_state <= S_HDR;
                default: r_state <= S_HDR;
            endcase
        end
    end

    assign bHdr_mac_dst = {f_b(r_hdr, 0), f_b(r_hdr, 1), f_b(r_hdr, 2),
                           f_b(r_hdr, 3), f_b(r_hdr, 4), f_b(r_hdr, 5)};
    assign bHdr_mac_src = {f_b(r_hdr, 6), f_b(r_hdr, 7), f_b(r_hdr, 8),
                           f_b(r_hdr, 9), f_b(r_hdr, 10), f_b(r_hdr, 11)};
    assign bHdr_ip_len  = {f_b(r_hdr, 16), f_b(r_hdr, 17)};
    assign bHdr_ip_id   = {f_b(r_hdr, 18), f_b(r_hdr, 19)};
    assign bHdr_ip_src  = {f_b(r_hdr, 26), f_b(r_hdr, 27), f_b(r_hdr, 28), f_b(r_hdr, 29)};
    assign bHdr_ip_dst  = {f_b(r_hdr, 30), f_b(r_hdr, 31), f_b(r_hdr, 32), f_b(r_hdr, 33)};
    assign bHdr_udp_src = {f_b(r_hdr, 34), f_b(r_hdr, 35)};
    assign bHdr_udp_dst = {f_b(r_hdr, 36), f_b(r_hdr, 37)};
    assign bHdr_udp_len = {f_b(r_hdr, 38), f_b(r_hdr, 39)};
    assign wHdr_valid   = r_hdr_valid;

    assign bData_out_data_out  = r_out_data;
    assign bData_out_keep_out  = r_out_keep;
    assign wData_out_valid_out = r_out_valid;
    assign wData_out_last_out  = r_out_last;

    assign bBadCheckSum_cnt    = r_bad;
    assign bEarlyTerminate_cnt = r_early;
    assign bUnsupportType_cnt  = r_unsup;
    assign bFiltered_cnt       = r_filt;
endmodule

// File: tb/tb_udp_rx_depacketizer.sv
// Scoreboard bench for udp_rx_depacketizer: frames are built byte-wise, the
// expected header and payload beats are queued at drive time and popped on output.
module tb_udp_rx_depacketizer;
    localparam int DW = 128;
    localparam int W  = DW / 8;
    localparam logic [15:0] PORT = 16'h1F90;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [DW-1:0] d;
        logic [W-1:0]  k;
        logic          l;
    } beat_t;
    typedef struct {
        logic [47:0] md, ms;
        logic [31:0] ips, ipd;
        logic [15:0] il, iid, us, ud, ul;
    } hdr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic [W-1:0]  kin = '0;
    logic vin = 1'b0, lin = 1'b0, rin;
    logic [15:0] fport = PORT;
    logic [47:0] mac_dst, mac_src;
    logic [31:0] ip_src, ip_dst;
    logic [15:0] ip_len, ip_id, udp_src, udp_dst, udp_len;
    logic hv, hr = 1'b1;
    logic [DW-1:0] od;
    logic [W-1:0]  ko;
    logic ov, ol, or_ = 1'b1;
    logic [31:0] c_bad, c_early, c_unsup, c_filt;

    beat_t exp_b[$];
    hdr_t  exp_h[$];
    beat_t eb;
    hdr_t  eh;
    int n_vec = 0, n_err = 0;
    int e_bad = 0, e_early = 0, e_unsup = 0, e_filt = 0;
    bit ignore_out = 1'b0;
    bit tog_mode = 1'b0;
    int hold_hdr = 0;

    udp_rx_depacketizer #(.DATA_W(DW), .FILTER_EN(1), .CNT_W(32)) dut (
        .wClk(clk), .wRst(rst),
        .bData_in_data_in(din), .bData_in_keep_in(kin),
        .wData_in_valid_in(vin), .wData_in_last_in(lin), .wData_in_ready_in(rin),
        .bFilter_port(fport),
        .bHdr_mac_dst(mac_dst), .bHdr_mac_src(mac_src),
        .bHdr_ip_src(ip_src), .bHdr_ip_dst(ip_dst),
        .bHdr_ip_len(ip_len), .bHdr_ip_id(ip_id),
        .bHdr_udp_src(udp_src), .bHdr_udp_dst(udp_dst), .bHdr_udp_len(udp_len),
        .wHdr_valid(hv), .wHdr_ready(hr),
        .bData_out_data_out(od), .bData_out_keep_out(ko),
        .wData_out_valid_out(ov), .wData_out_last_out(ol), .wData_out_ready_out(or_),
        .bBadCheckSum_cnt(c_bad), .bEarlyTerminate_cnt(c_early),
        .bUnsupportType_cnt(c_unsup), .bFiltered_cnt(c_filt)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bq_t mkframe(int n, logic [15:0] et, logic [15:0] dp, bit bad, int seed);
        bq_t f;
        logic [31:0] s;
        logic [15:0] cs;
        int len;
        len = (n < 42) ? 42 : n;
        for (int i = 0; i < len; i++) f.push_back(8'(seed * 31 + i * 7 + 3));
        for (int i = 0; i < 6; i++) begin
            f[i]   = 8'(16 + i);
            f[6+i] = 8'(32 + i + seed);
        end
        f[12] = et[15:8]; f[13] = et[7:0]; f[14] = 8'h45; f[15] = 8'h00;
        f[16] = 8'((n - 14) >> 8); f[17] = 8'(n - 14);
        f[18] = 8'(seed >> 8); f[19] = 8'(seed);
        f[20] = 8'h40; f[21] = 8'h00; f[22] = 8'd64; f[23] = 8'd17;
        f[24] = 8'h00; f[25] = 8'h00;
        f[26] = 8'd192; f[27] = 8'd168; f[28] = 8'd1; f[29] = 8'(seed);
        f[30] = 8'd10; f[31] = 8'h00; f[32] = 8'h00; f[33] = 8'd2;
        f[34] = 8'h12; f[35] = 8'(seed); f[36] = dp[15:8]; f[37] = dp[7:0];
        f[38] = 8'((n - 34) >> 8); f[39] = 8'(n - 34); f[40] = 8'h00; f[41] = 8'h00;
        s = '0;
        for (int i = 14; i < 34; i += 2) s = s + {16'd0, f[i], f[i+1]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        cs = ~s[15:0];
        if (bad) cs = cs ^ 16'h0101;
        f[24] = cs[15:8]; f[25] = cs[7:0];
        while (f.size() > n) void'(f.pop_back());
        return f;
    endfunction

    function automatic void push_expect(bq_t f);
        hdr_t h;
        beat_t b;
        h.md  = {f[0], f[1], f[2], f[3], f[4], f[5]};
        h.ms  = {f[6], f[7], f[8], f[9], f[10], f[11]};
        h.il  = {f[16], f[17]};
        h.iid = {f[18], f[19]};
        h.ips = {f[26], f[27], f[28], f[29]};
        h.ipd = {f[30], f[31], f[32], f[33]};
        h.us  = {f[34], f[35]};
        h.ud  = {f[36], f[37]};
        h.ul  = {f[38], f[39]};
        exp_h.push_back(h);
        for (int off = 42; off < f.size(); off += W) begin
            b.d = '0;
            b.k = '0;
            for (int j = 0; j < W; j++)
                if (off + j < f.size()) begin
                    b.d[8*j +: 8] = f[off+j];
                    b.k[j] = 1'b1;
                end
            b.l = (off + W >= f.size());
            exp_b.push_back(b);
        end
    endfunction

    task automatic send(bq_t f, bit no_last, output int stalls);
        int tmo;
        stalls = 0;
        for (int off = 0; off < f.size(); off += W) begin
            @(negedge clk);
            din = '0;
            kin = '0;
            for (int j = 0; j < W; j++)
                if (off + j < f.size()) begin
                    din[8*j +: 8] = f[off+j];
                    kin[j] = 1'b1;
                end
            vin = 1'b1;
            lin = !no_last && (off + W >= f.size());
            #1;
            tmo = 0;
            while (!rin && tmo < 200) begin
                @(negedge clk);
                #1;
                stalls++;
                tmo++;
            end
            check("send_ready", rin, 1);
        end
        @(negedge clk);
        vin = 1'b0;
        lin = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_b.size() != 0 || exp_h.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check("drain", 64'(exp_b.size() + exp_h.size()), 0);
    endtask

    task automatic check_cnts();
        check("cnt_bad", c_bad, 64'(e_bad));
        check("cnt_early", c_early, 64'(e_early));
        check("cnt_unsup", c_unsup, 64'(e_unsup));
        check("cnt_filt", c_filt, 64'(e_filt));
    endtask

    always @(posedge clk) begin
        #1;
        or_ = tog_mode ? !or_ : 1'b1;
        if (hv && hold_hdr > 0) begin
            hr = 1'b0;
            hold_hdr--;
        end else begin
            hr = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && !ignore_out) begin
            if (hv && hr) begin
                check("hdr_pending", exp_h.size() != 0, 1);
                if (exp_h.size() != 0) begin
                    eh = exp_h.pop_front();
                    check("mac_dst", mac_dst, eh.md);
                    check("mac_src", mac_src, eh.ms);
                    check("ip_src", ip_src, eh.ips);
                    check("ip_dst", ip_dst, eh.ipd);
                    check("ip_len", ip_len, eh.il);
                    check("ip_id", ip_id, eh.iid);
                    check("udp_src", udp_src, eh.us);
                    check("udp_dst", udp_dst, eh.ud);
                    check("udp_len", udp_len, eh.ul);
                end
            end
            if (ov && or_) begin
                check("pay_pending", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) begin
                    eb = exp_b.pop_front();
                    check("pay_keep", ko, eb.k);
                    check("pay_last", ol, eb.l);
                    for (int j = 0; j < W; j++)
                        if (eb.k[j]) check("pay_byte", od[8*j +: 8], eb.d[8*j +: 8]);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t f, g;
        int st;
        int lens[6] = '{42, 48, 52, 58, 60, 100};
        repeat (3) @(negedge clk);
        check("rst_in_ready", rin, 0);
        check("rst_hdr_valid", hv, 0);
        check("rst_out_valid", ov, 0);
        check("rst_keep", ko, 0);
        check("rst_mac_dst", mac_dst, 0);
        check_cnts();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        f = mkframe(62, 16'h0800, PORT, 1'b0, 1);
        push_expect(f);
        send(f, 1'b0, st);
        wait_idle();
        check_cnts();

        f = mkframe(62, 16'h0800, PORT, 1'b1, 2);
        send(f, 1'b0, st);
        wait_idle();
        e_bad = 1;
        check_cnts();
        check("cs_in_stalls", 64'(st), 0);

        f = mkframe(40, 16'h0800, PORT, 1'b0, 3);
        send(f, 1'b0, st);
        wait_idle();
        e_early = 1;
        check_cnts();
        f = mkframe(62, 16'h0800, PORT, 1'b0, 4);
        push_expect(f);
        send(f, 1'b0, st);
        wait_idle();

        f = mkframe(62, 16'h86DD, PORT, 1'b0, 5);
        send(f, 1'b0, st);
        wait_idle();
        e_unsup = 1;
        check_cnts();
        fport = 16'h0050;
        f = mkframe(62, 16'h0800, PORT, 1'b0, 6);
        send(f, 1'b0, st);
        wait_idle();
        e_filt = 1;
        check_cnts();
        fport = PORT;

        foreach (lens[i]) begin
            f = mkframe(lens[i], 16'h0800, PORT, 1'b0, 10 + i);
            push_expect(f);
            send(f, 1'b0, st);
        end
        wait_idle();
        check_cnts();

        tog_mode = 1'b1;
        hold_hdr = 5;
        f = mkframe(120, 16'h0800, PORT, 1'b0, 20);
        push_expect(f);
        send(f, 1'b0, st);
        check("stall_in_ready", st >= 5, 1);
        wait_idle();
        tog_mode = 1'b0;

        ignore_out = 1'b1;
        f = mkframe(120, 16'h0800, PORT, 1'b0, 21);
        g = f[0:79];
        send(g, 1'b1, st);
        rst = 1'b1;
        #1;
        check("mrst_out_valid", ov, 0);
        check("mrst_hdr_valid", hv, 0);
        check("mrst_keep", ko, 0);
        check("mrst_in_ready", rin, 0);
        e_bad = 0; e_early = 0; e_unsup = 0; e_filt = 0;
        check_cnts();
        @(negedge clk);
        rst = 1'b0;
        ignore_out = 1'b0;
        @(negedge clk);
        f = mkframe(62, 16'h0800, PORT, 1'b0, 22);
        push_expect(f);
        send(f, 1'b0, st);
        wait_idle();
        check_cnts();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
